// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for the data-memory responder
// Contents: request size encoding, controller state encoding, byte-enable and
//           store-lane replication helpers.
package dmem_pkg;
    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;
    // Zero enables mean the access is misaligned or uses the reserved size.
    function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] a);
        return sz == SZ_B ? 4'b0001 << a :
               sz == SZ_H ? (a[0] ? 4'b0000 : 4'b0011 << {a[1], 1'b0}) :
               (sz == SZ_W && a == 2'b00) ? 4'b1111 : 4'b0000;
    endfunction
    // Replicate right-aligned store data onto every lane so the enables pick the right one.
    function automatic logic [31:0] lane_data(input size_e sz, input logic [31:0] d);
        return sz == SZ_B ? {4{d[7:0]}} : sz == SZ_H ? {2{d[15:0]}} : d;
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core <-> data-memory request/response bundle
// Signals: dmem_req_valid/we/addr/data/size_1/size_0 (core -> memory),
//          dmem_req_ready, dmem_resp_valid, dmem_resp_data (memory -> core).
// Modports: master (core side), slave (memory side).
interface dmem_responder_if;
    logic        dmem_req_valid;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_data;
    logic        dmem_req_size_0;
    logic        dmem_req_size_1;
    logic        dmem_req_ready;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;
    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_data,
               dmem_req_size_0, dmem_req_size_1,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );
    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_data,
               dmem_req_size_0, dmem_req_size_1,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );
endinterface

// File: rtl/dmem_resp_pipe.sv
// dmem_resp_pipe: LATENCY-stage valid+data shift register for load responses
// Ports: clock, reset (async active-low), i_valid/i_data (stage 0 input),
//        o_valid/o_data (last stage output).
module dmem_resp_pipe #(
    parameter int LATENCY = 2,
    parameter int W       = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);
    logic         r_v [LATENCY];
    logic [W-1:0] r_d [LATENCY];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_v[i] <= 1'b0;
                r_d[i] <= '0;
            end
        end else begin
            r_v[0] <= i_valid;
            r_d[0] <= i_data;
            for (int i = 1; i < LATENCY; i++) begin
                r_v[i] <= r_v[i-1];
                r_d[i] <= r_d[i-1];
            end
        end
    end
    assign o_valid = r_v[LATENCY-1];
    assign o_data  = r_d[LATENCY-1];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory model with sized stores and fixed-latency loads
// Ports: clock, reset (async active-low), bus (dmem_responder_if.slave),
//        stall_inject (forces ready low), init_done (array cleared),
//        misaligned_err (sticky misaligned/reserved-size flag).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int AW      = $clog2(DEPTH),
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    input  logic             stall_inject,
    output logic             init_done,
    output logic             misaligned_err
);
    state_e        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_mis;
    logic [31:0]   r_mem [DEPTH];
    size_e         w_size;
    logic [AW-1:0] w_idx;
    logic          w_acc;
    logic          w_st;
    logic          w_ld;
    logic [3:0]    w_be;
    logic [31:0]   w_wd;
    logic [31:0]   w_rd;
    logic          w_unused;
    assign w_size             = size_e'({bus.dmem_req_size_1, bus.dmem_req_size_0});
    assign w_idx              = bus.dmem_req_addr[AW+1:2];
    assign bus.dmem_req_ready = r_state == RUN && !stall_inject;
    assign w_acc              = bus.dmem_req_valid && bus.dmem_req_ready;
    assign w_st               = w_acc && bus.dmem_req_we;
    assign w_ld               = w_acc && !bus.dmem_req_we;
    assign w_be               = byte_en(w_size, bus.dmem_req_addr[1:0]);
    assign w_wd               = lane_data(w_size, bus.dmem_req_data);
    assign w_rd               = r_mem[w_idx];
    assign init_done          = r_state == RUN;
    assign misaligned_err     = r_mis;
    // Upper address bits are deliberately ignored so addresses wrap.
    assign w_unused           = &{1'b0, bus.dmem_req_addr[31:AW+2]};
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_mis   <= 1'b0;
        end else begin
            if (r_state == CLEAR) begin
                r_cnt <= r_cnt + AW'(1);
                if (r_cnt == AW'(DEPTH - 1)) r_state <= RUN;
            end
            if (w_acc && w_be == 4'b0000) r_mis <= 1'b1;
        end
    end
    // A misaligned store has no enables, so it writes nothing.
    always_ff @(posedge clock) begin
        if (r_state == CLEAR) r_mem[r_cnt] <= '0;
        else if (w_st)
            for (int i = 0; i < 4; i++)
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
    end
    dmem_resp_pipe #(.LATENCY(LATENCY), .W(32)) u_pipe (
        .clock   (clock),
        .reset   (reset),
        .i_valid (w_ld),
        .i_data  (w_rd),
        .o_valid (bus.dmem_resp_valid),
        .o_data  (bus.dmem_resp_data)
    );
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side end of the CPU data-memory port. Accepts `dmem_req_*` requests from the core and performs byte/half/word stores into a local word-array.
- Returns load data on `dmem_resp_*` after a fixed, parameterised latency.
- Clears its array after reset and supports injected back-pressure.
- Sits beside the CPU in simulation/FPGA top levels as the data-memory model.

Parameters:
- DEPTH, 4096: number of 32-bit words; must be a power of two.
- AW, $clog2(DEPTH): word-index width.
- LATENCY, 2: cycles from load acceptance to `dmem_resp_valid`; legal range 1..8.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- dmem_req_valid  in  1  request present
- dmem_req_we  in  1  1 = store, 0 = load
- dmem_req_addr  in  32  byte address
- dmem_req_data  in  32  store data, right-aligned
- dmem_req_size_0  in  1  size bit 0
- dmem_req_size_1  in  1  size bit 1; {size_1,size_0}: 00 byte, 01 half, 10 word, 11 reserved
- stall_inject  in  1  forces `dmem_req_ready` low (verification back-pressure)
- dmem_req_ready  out  1  request accepted when valid & ready
- dmem_resp_valid  out  1  load data valid, one cycle per accepted load
- dmem_resp_data  out  32  full aligned word read at acceptance
- init_done  out  1  array clear complete
- misaligned_err  out  1  sticky: a misaligned or reserved-size request was seen

Behaviour:
- Reset (reset==0, async):
  - FSM goes to CLEAR and the clear counter goes to 0.
  - `dmem_req_ready`=0, `dmem_resp_valid`=0, `dmem_resp_data`=0, `init_done`=0, `misaligned_err`=0.
  - Every latency-pipe valid bit is cleared.
- FSM CLEAR:
  - Writes 0 to word[counter] each cycle and increments the counter.
  - At counter==DEPTH-1 the write happens and the FSM moves to RUN on the next edge.
  - CLEAR lasts exactly DEPTH cycles. `init_done` goes high on entry to RUN and stays high until the next reset.
- FSM RUN: no exit except reset.
- Ready: `dmem_req_ready` = (state==RUN) & ~`stall_inject`. It is combinational from the registered state and the input.
- Word index = addr[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Alignment:
  - Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - A misaligned request is still accepted and sets `misaligned_err`.
  - A misaligned store writes nothing. A misaligned load returns the aligned word normally.
- Store on acceptance (valid & ready & we):
  - Byte: data[7:0] goes to lane addr[1:0].
  - Half: data[15:0] goes to lanes {addr[1],0}..{addr[1],1}.
  - Word: all 4 lanes.
  - Other lanes are untouched. The write commits at the accepting edge.
  - Stores produce no response.
- Load on acceptance (valid & ready & ~we):
  - The word is read at the accepting edge and enters stage 0 of a LATENCY-deep valid/data shift pipe.
  - `dmem_resp_valid` is high exactly LATENCY cycles after the acceptance edge, for one cycle.
  - Data is the full word; the core extracts and extends the sub-word.
- Ordering:
  - A load accepted the cycle after a store to the same word returns the stored value.
  - Data is captured at acceptance, so later stores never alter an in-flight load.
- Back-to-back: one load per cycle is sustainable and responses stream out in order. There is no response back-pressure; the core must always accept.
- Requests while `dmem_req_ready`=0 are ignored; the requester holds them.
- Reset mid-operation: in-flight loads are discarded, no response is emitted, and CLEAR restarts.

Decomposition:
- Shared package `dmem_pkg`:
  - Size enum: SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_RSV=2'b11.
  - FSM enum: CLEAR, RUN.
  - Function: byte-enable/lane-shift from (size, addr[1:0]).
- One sub-module, `dmem_resp_pipe`: parameterised LATENCY-stage valid+data shift register with async active-low reset.

Test Plan:
- Reset, DEPTH=16: `init_done` rises 16 cycles after release, `dmem_req_ready`=1 afterwards; a load of 0x8 returns 0x00000000 at cycle accept+2.
- Word store 0xDEADBEEF @0x10, then byte store 0xA5 @0x11, then load @0x10 -> `dmem_resp_data`=0xDEADA5EF.
- Half store 0x1234 @0x22, then load @0x20 -> 0x1234xxxx with the low half unchanged.
- Four back-to-back loads @0x0,0x4,0x8,0xC holding 1,2,3,4 -> four consecutive responses 1,2,3,4 starting accept+LATENCY.
- Word store @0x13 -> accepted, `misaligned_err`=1, memory unchanged; `stall_inject`=1 for 3 cycles -> ready low and the held request is accepted on the first cycle `stall_inject` is low.
- Assert reset one cycle after a load is accepted -> no `dmem_resp_valid`; CLEAR reruns; `misaligned_err` is cleared.
